// File: rtl/io_stream_pkg.sv
// Shared opcode, status-bit and field-offset definitions for the streaming register file.
// Request/response words are packed {signal/status, id, addr, data}, with signal at the MSBs.
package io_stream_pkg;

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_SET   = 2'b10,
        OP_CLR   = 2'b11
    } op_e;

    localparam int ST_MOD = 2;

    function automatic int st_err(input int signal_width);
        return signal_width - 1;
    endfunction

    function automatic int data_lsb();
        return 0;
    endfunction

    function automatic int addr_lsb(input int data_width);
        return data_width;
    endfunction

    function automatic int id_lsb(input int data_width, input int addr_width);
        return data_width + addr_width;
    endfunction

    function automatic int sig_lsb(input int data_width, input int addr_width, input int id_width);
        return data_width + addr_width + id_width;
    endfunction

endpackage

// File: rtl/io_resp_fifo.sv
// Response FIFO with a registered first-word-fall-through head; the head register holds
// the oldest entry and the ring buffer holds the entries queued behind it.
module io_resp_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             valid_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] head_q, head_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             mem_we;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign valid_o = ~empty_o;
    assign dout_o  = head_q;

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // The head is refilled from the ring, or straight from din when the ring is empty.
    always_comb begin
        head_d   = head_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_we   = 1'b0;
        case ({do_push, do_pop})
            2'b10: begin
                count_d = count_q + CW'(1);
                if (empty_o) begin
                    head_d = din_i;
                end else begin
                    mem_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + PW'(1);
                end
            end
            2'b01: begin
                count_d = count_q - CW'(1);
                if (count_q > CW'(1)) begin
                    head_d   = mem_q[rd_ptr_q];
                    rd_ptr_d = rd_ptr_q + PW'(1);
                end
            end
            2'b11: begin
                if (count_q == CW'(1)) begin
                    head_d = din_i;
                end else begin
                    head_d   = mem_q[rd_ptr_q];
                    rd_ptr_d = rd_ptr_q + PW'(1);
                    mem_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + PW'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            head_q   <= head_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/io_regfile_stream.sv
// Streaming register file: one request per accepted beat, one response queued per request.
// Writes and read-modify-writes commit at the accepting edge; responses drain through a FIFO.
module io_regfile_stream
    import io_stream_pkg::*;
#(
    parameter int DW            = 32,
    parameter int SIGNAL_WIDTH  = 4,
    parameter int ID_WIDTH      = 4,
    parameter int ADDR_WIDTH    = 8,
    parameter int DATA_WIDTH    = 16,
    parameter int DEPTH         = 256,
    parameter int FIFO_DEPTH    = 4,
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     up_valid,
    input  logic [DW-1:0]            up_data,
    output logic                     up_ready,
    output logic                     down_valid,
    output logic [DW-1:0]            down_data,
    input  logic                     down_ready,
    output logic [ERR_CNT_WIDTH-1:0] err_cnt
);

    localparam int DATA_LSB = data_lsb();
    localparam int ADDR_LSB = addr_lsb(DATA_WIDTH);
    localparam int ID_LSB   = id_lsb(DATA_WIDTH, ADDR_WIDTH);
    localparam int SIG_LSB  = sig_lsb(DATA_WIDTH, ADDR_WIDTH, ID_WIDTH);
    localparam int ST_ERR   = st_err(SIGNAL_WIDTH);
    localparam int RAM_AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

    op_e                     req_op;
    logic [ID_WIDTH-1:0]     req_id;
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic [DATA_WIDTH-1:0]   req_data;
    logic [RAM_AW-1:0]       ram_idx;
    logic                    in_range;
    logic                    accept;
    logic                    ram_we;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    pop;
    logic                    unused_sig_bits;

    logic [DATA_WIDTH-1:0]   ram_q [DEPTH];
    logic [DATA_WIDTH-1:0]   ram_rd;
    logic [DATA_WIDTH-1:0]   ram_wdata;
    logic [DATA_WIDTH-1:0]   resp_data;
    logic [SIGNAL_WIDTH-1:0] resp_status;
    logic [DW-1:0]           resp_word;

    logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;

    assign req_op   = op_e'(up_data[SIG_LSB +: 2]);
    assign req_id   = up_data[ID_LSB +: ID_WIDTH];
    assign req_addr = up_data[ADDR_LSB +: ADDR_WIDTH];
    assign req_data = up_data[DATA_LSB +: DATA_WIDTH];
    assign ram_idx  = req_addr[RAM_AW-1:0];

    // Upper signal bits carry no meaning on the request side.
    assign unused_sig_bits = ^up_data[SIG_LSB + SIGNAL_WIDTH - 1 : SIG_LSB + 2];

    assign in_range = ({1'b0, req_addr} < DEPTH_W);
    assign up_ready = ~fifo_full;
    assign accept   = up_valid & up_ready;
    assign ram_we   = accept & in_range & (req_op != OP_READ);
    assign pop      = down_valid & down_ready;
    assign ram_rd   = in_range ? ram_q[ram_idx] : '0;

    always_comb begin
        ram_wdata = ram_rd;
        case (req_op)
            OP_WRITE: ram_wdata = req_data;
            OP_SET:   ram_wdata = ram_rd | req_data;
            OP_CLR:   ram_wdata = ram_rd & ~req_data;
            default:  ram_wdata = ram_rd;
        endcase
    end

    // SET/CLR report the value they found; WRITE reports what it stored.
    always_comb begin
        resp_data = '0;
        if (in_range) begin
            resp_data = (req_op == OP_WRITE) ? req_data : ram_rd;
        end
    end

    always_comb begin
        resp_status         = '0;
        resp_status[1:0]    = req_op;
        resp_status[ST_MOD] = in_range & (req_op != OP_READ);
        resp_status[ST_ERR] = ~in_range;
    end

    assign resp_word = {resp_status, req_id, req_addr, resp_data};

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (accept && !in_range && !(&err_cnt_q)) begin
            err_cnt_d = err_cnt_q + ERR_CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;

    // Register contents survive reset on purpose.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram_q[ram_idx] <= ram_wdata;
        end
    end

    io_resp_fifo #(
        .WIDTH (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_resp_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (accept),
        .din_i   (resp_word),
        .pop_i   (pop),
        .dout_o  (down_data),
        .valid_o (down_valid),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

endmodule

// File: tb/tb_io_regfile_stream.sv
// Bench for io_regfile_stream built with DEPTH=200 and a 2-bit error counter.
// Responses are checked in order against an expected queue filled as requests are accepted.
module tb_io_regfile_stream;

    logic        clk;
    logic        rst_n;
    logic        up_valid;
    logic [31:0] up_data;
    logic        up_ready;
    logic        down_valid;
    logic [31:0] down_data;
    logic        down_ready;
    logic [1:0]  err_cnt;

    logic [31:0] exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;

    typedef struct {
        logic [3:0]  sig;
        logic [3:0]  id;
        logic [7:0]  addr;
        logic [15:0] data;
        logic [3:0]  exp_st;
        logic [15:0] exp_data;
        logic [1:0]  exp_err;
    } vec_t;

    vec_t vecs[14];

    io_regfile_stream #(
        .DEPTH         (200),
        .ERR_CNT_WIDTH (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .up_valid   (up_valid),
        .up_data    (up_data),
        .up_ready   (up_ready),
        .down_valid (down_valid),
        .down_data  (down_data),
        .down_ready (down_ready),
        .err_cnt    (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs change only #1 after a rising edge; the negedge sample predicts the next edge.
    task automatic send(input logic [3:0] sig, input logic [3:0] id, input logic [7:0] addr,
                        input logic [15:0] data, input logic [31:0] exp_word);
        int  t;
        logic ok;
        t  = 0;
        ok = 1'b0;
        up_valid = 1'b1;
        up_data  = {sig, id, addr, data};
        while (!ok && t < 100) begin
            @(negedge clk);
            ok = up_ready;
            t++;
        end
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept_timeout: id %h not accepted in %0d cycles", id, t);
            up_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            exp_q.push_back(exp_word);
            up_valid = 1'b0;
        end
    endtask

    task automatic send_err(input logic [3:0] sig, input logic [3:0] id, input logic [7:0] addr);
        send(sig, id, addr, 16'h5A5A, {2'b10, sig[1:0], id, addr, 16'h0000});
    endtask

    always @(negedge clk) begin
        if (rst_n && down_valid && down_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL resp_unexpected: got %h expected none", down_data);
            end else begin
                check("resp", down_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        rst_n      = 1'b0;
        up_valid   = 1'b0;
        up_data    = '0;
        down_ready = 1'b1;

        vecs[0]  = '{4'h1, 4'h1, 8'h05, 16'hBEEF, 4'b0101, 16'hBEEF, 2'd0};
        vecs[1]  = '{4'h0, 4'h2, 8'h05, 16'h0000, 4'b0000, 16'hBEEF, 2'd0};
        vecs[2]  = '{4'h1, 4'h3, 8'h10, 16'h00F0, 4'b0101, 16'h00F0, 2'd0};
        vecs[3]  = '{4'h2, 4'h4, 8'h10, 16'h000F, 4'b0110, 16'h00F0, 2'd0};
        vecs[4]  = '{4'h3, 4'h5, 8'h10, 16'h00C0, 4'b0111, 16'h00FF, 2'd0};
        vecs[5]  = '{4'h0, 4'h6, 8'h10, 16'h0000, 4'b0000, 16'h003F, 2'd0};
        vecs[6]  = '{4'hD, 4'h7, 8'h11, 16'h1111, 4'b0101, 16'h1111, 2'd0};
        vecs[7]  = '{4'h8, 4'h8, 8'h11, 16'hFFFF, 4'b0000, 16'h1111, 2'd0};
        vecs[8]  = '{4'h1, 4'h9, 8'hC7, 16'h7777, 4'b0101, 16'h7777, 2'd0};
        vecs[9]  = '{4'h1, 4'hA, 8'hC8, 16'h1234, 4'b1001, 16'h0000, 2'd1};
        vecs[10] = '{4'h0, 4'hB, 8'hC8, 16'h0000, 4'b1000, 16'h0000, 2'd2};
        vecs[11] = '{4'h0, 4'hC, 8'hC7, 16'h0000, 4'b0000, 16'h7777, 2'd2};
        vecs[12] = '{4'h2, 4'hD, 8'hC7, 16'h0008, 4'b0110, 16'h7777, 2'd2};
        vecs[13] = '{4'h0, 4'hE, 8'hC7, 16'h0000, 4'b0000, 16'h777F, 2'd2};

        repeat (3) @(posedge clk);
        #1;
        check("rst_up_ready", {31'd0, up_ready}, 32'd1);
        check("rst_down_valid", {31'd0, down_valid}, 32'd0);
        check("rst_down_data", down_data, 32'd0);
        check("rst_err_cnt", {30'd0, err_cnt}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Table: basic ops, RMW chains, ignored signal bits, DEPTH boundary.
        for (int i = 0; i < 14; i++) begin
            send(vecs[i].sig, vecs[i].id, vecs[i].addr, vecs[i].data,
                 {vecs[i].exp_st, vecs[i].id, vecs[i].addr, vecs[i].exp_data});
            check("latency_valid", {31'd0, down_valid}, 32'd1);
            check("err_cnt_tbl", {30'd0, err_cnt}, {30'd0, vecs[i].exp_err});
        end
        repeat (2) @(posedge clk);
        #1;
        check("idle_down_valid", {31'd0, down_valid}, 32'd0);

        // FIFO full: four accepted, the rest wait until responses drain.
        down_ready = 1'b0;
        send(4'h1, 4'h1, 8'h30, 16'h0100, {4'b0101, 4'h1, 8'h30, 16'h0100});
        send(4'h0, 4'h2, 8'h30, 16'h0000, {4'b0000, 4'h2, 8'h30, 16'h0100});
        send(4'h1, 4'h3, 8'h31, 16'h00AA, {4'b0101, 4'h3, 8'h31, 16'h00AA});
        send(4'h0, 4'h4, 8'h31, 16'h0000, {4'b0000, 4'h4, 8'h31, 16'h00AA});
        check("full_up_ready", {31'd0, up_ready}, 32'd0);
        fork
            begin
                send(4'h2, 4'h5, 8'h30, 16'h0001, {4'b0110, 4'h5, 8'h30, 16'h0100});
                send(4'h0, 4'h6, 8'h30, 16'h0000, {4'b0000, 4'h6, 8'h30, 16'h0101});
            end
            begin
                repeat (2) @(posedge clk);
                #1;
                check("stall_hold_a", down_data, exp_q[0]);
                repeat (3) @(posedge clk);
                #1;
                check("stall_up_ready", {31'd0, up_ready}, 32'd0);
                check("stall_hold_b", down_data, exp_q[0]);
                check("stall_count", exp_q.size(), 32'd4);
                down_ready = 1'b1;
            end
        join
        repeat (8) @(posedge clk);
        #1;

        // Error counter saturates at 3.
        send_err(4'h1, 4'h1, 8'hD0);
        check("sat_1", {30'd0, err_cnt}, 32'd3);
        send_err(4'h2, 4'h2, 8'hFF);
        send_err(4'h3, 4'h3, 8'hE0);
        send_err(4'h0, 4'h4, 8'hC9);
        send_err(4'h1, 4'h5, 8'hC8);
        check("sat_hold", {30'd0, err_cnt}, 32'd3);
        repeat (4) @(posedge clk);
        #1;

        // Reset with queued responses: queue dropped, RAM kept.
        down_ready = 1'b0;
        send(4'h1, 4'h7, 8'h40, 16'hCAFE, {4'b0101, 4'h7, 8'h40, 16'hCAFE});
        send(4'h0, 4'h8, 8'h40, 16'h0000, {4'b0000, 4'h8, 8'h40, 16'hCAFE});
        send(4'h0, 4'h9, 8'h05, 16'h0000, {4'b0000, 4'h9, 8'h05, 16'hBEEF});
        check("pre_rst_valid", {31'd0, down_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("arst_down_valid", {31'd0, down_valid}, 32'd0);
        check("arst_up_ready", {31'd0, up_ready}, 32'd1);
        check("arst_err_cnt", {30'd0, err_cnt}, 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        down_ready = 1'b1;
        @(posedge clk);
        #1;
        send(4'h0, 4'hA, 8'h40, 16'h0000, {4'b0000, 4'hA, 8'h40, 16'hCAFE});
        send(4'h0, 4'hB, 8'h10, 16'h0000, {4'b0000, 4'hB, 8'h10, 16'h003F});
        send_err(4'h0, 4'hC, 8'hC8);
        check("post_rst_err", {30'd0, err_cnt}, 32'd1);

        for (int t = 0; t < 50 && exp_q.size() != 0; t++) begin
            @(posedge clk);
        end
        #1;
        check("drain_left", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
